// File: rtl/addsub_pkg.sv
// addsub_pkg: shared opcode constants, FSM state type and counter-width helper
// for the slice-serial adder/subtractor.
package addsub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational SLICE-bit add/sub slice; also exposes the carry
// into the slice MSB so the top can derive signed overflow on the last slice.
module addsub_slice import addsub_pkg::*; #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [SLICE-1:0] w_b;
  assign w_b = b ^ {SLICE{op != OP_ADD}};
  assign {cout, sum} = {1'b0, a} + {1'b0, w_b} + {{SLICE{1'b0}}, cin};
  // sum MSB = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR
  assign c_msb_in = sum[SLICE-1] ^ a[SLICE-1] ^ w_b[SLICE-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: WIDTH-bit add/sub processed SLICE bits per cycle through one
// time-multiplexed slice, with valid/ready handshakes and carry/ovf/zero flags.
module addsub_serial import addsub_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (SLICE < 1 || WIDTH % SLICE != 0 || NSLICE < 1) begin : g_bad_param
    $error("addsub_serial: WIDTH must be a positive multiple of SLICE");
  end

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_ans;
  logic             r_op, r_carry, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [SLICE-1:0] w_sum;
  logic             w_cout, w_cmsb, w_last;

  assign w_last = r_cnt == LAST;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a        (r_a[r_cnt*SLICE +: SLICE]),
    .b        (r_b[r_cnt*SLICE +: SLICE]),
    .cin      (r_carry),
    .op       (r_op),
    .sum      (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // flags are only meaningful with out_valid, so they read 0 elsewhere
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    ans       = r_ans;
    carry     = out_valid & r_carry;
    ovf       = out_valid & r_ovf;
    zero      = out_valid & ~|r_ans;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_ans   <= '0;
    end else if (in_valid && in_ready) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_carry <= cin ^ (op == OP_SUB);
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_ans[r_cnt*SLICE +: SLICE] <= w_sum;
      r_carry                     <= w_cout;
      r_cnt                       <= r_cnt + 1'b1;
      if (w_last) r_ovf <= w_cmsb ^ w_cout;
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed vector table plus handshake/reset corner cases on
// the default build, and random sweeps on 8/8 and 32/4 builds.
module tb_addsub_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, carry, ovf, zero;
  logic [15:0] a = '0, b = '0, ans;

  logic        v8 = 1'b0, rdy8, o8, c8, ov8, z8;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        v32 = 1'b0, rdy32, o32, c32, ov32, z32;
  logic [31:0] a32 = '0, b32 = '0, s32;

  addsub_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .ans(ans),
    .carry(carry), .ovf(ovf), .zero(zero));

  addsub_serial #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .cin(cin), .op(op), .out_valid(o8), .out_ready(1'b1), .ans(s8),
    .carry(c8), .ovf(ov8), .zero(z8));

  addsub_serial #(.WIDTH(32), .SLICE(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32),
    .cin(cin), .op(op), .out_valid(o32), .out_ready(1'b1), .ans(s32),
    .carry(c32), .ovf(ov32), .zero(z32));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic to, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    a = ta; b = tb_; cin = tc; op = to; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1 lat++; end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, in_ready, 1);
    chk({nm, "_out_valid_drop"}, out_valid, 0);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin, op;
    logic [15:0] ans;
    logic        c, v, z;
  } vec_t;
  vec_t vt[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [8:0]  e9;
    logic [32:0] e33;
    vt[0] = '{16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
    vt[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0};
    vt[7] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    #12;
    chk("reset_ctrl", {in_ready, out_valid, carry, ovf, zero}, 5'b10000);
    chk("reset_ans", ans, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].op, lat);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_ans", i), ans, vt[i].ans);
      chk($sformatf("v%0d_carry", i), carry, vt[i].c);
      chk($sformatf("v%0d_ovf", i), ovf, vt[i].v);
      chk($sformatf("v%0d_zero", i), zero, vt[i].z);
      release_out($sformatf("v%0d", i));
    end

    // backpressure: result held, new operands ignored
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); in_valid = k[0]; a = 16'h0001; b = 16'h0001; op = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_ans", k), ans, 16'h8000);
      chk($sformatf("bp%0d_flags", k), {out_valid, in_ready, carry, ovf, zero}, 5'b10010);
    end
    in_valid = 1'b0;
    release_out("bp");
    @(posedge clk); #1 chk("bp_no_stray_op", out_valid, 0);

    // reset two cycles into RUN
    @(negedge clk); a = 16'h1234; b = 16'h0FF1; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_run_ctrl", {in_ready, out_valid, carry, ovf, zero}, 5'b10000);
    chk("rst_run_ans", ans, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_result", {carry, zero, ans}, {2'b11, 16'h0000});
    release_out("post_rst");

    // reset while in DONE
    run_op(16'h1234, 16'h0FF1, 1'b0, 1'b0, lat);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_ctrl", {in_ready, out_valid, carry, ovf, zero}, 5'b10000);
    chk("rst_done_ans", ans, 0);
    @(negedge clk); rst_n = 1'b1;

    // WIDTH=8/SLICE=8 sweep
    for (int i = 0; i < 1000; i++) begin
      int l;
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom); op = 1'($urandom); v8 = 1'b1;
      @(posedge clk); #1 v8 = 1'b0;
      l = 1;
      while (!o8 && l < 50) begin @(posedge clk); #1 l++; end
      e9 = {1'b0, a8} + {1'b0, b8 ^ {8{op}}} + {8'd0, cin ^ op};
      chk($sformatf("w8_%0d_res", i), {c8, s8}, e9);
      chk($sformatf("w8_%0d_latency", i), l, 2);
      @(posedge clk);
    end

    // WIDTH=32/SLICE=4 sweep
    for (int i = 0; i < 1000; i++) begin
      int l;
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; cin = 1'($urandom); op = 1'($urandom); v32 = 1'b1;
      @(posedge clk); #1 v32 = 1'b0;
      l = 1;
      while (!o32 && l < 50) begin @(posedge clk); #1 l++; end
      e33 = {1'b0, a32} + {1'b0, b32 ^ {32{op}}} + {32'd0, cin ^ op};
      chk($sformatf("w32_%0d_res", i), {c32, s32}, e33);
      chk($sformatf("w32_%0d_latency", i), l, 9);
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
